// File: rtl/cid_to_gcid_3d_pipe.sv
// cid_to_gcid_3d_pipe
//   Pipelined 3-D cell-ID translator. Each request carries one local
//   neighbour code per axis (01=minus, 10=self, 11=plus, 00=invalid) and
//   a fold index. The fold index selects this node's home cell. The block
//   returns the global cell ID per axis with periodic wrap, wrap-direction
//   flags and an error flag. There are two register stages, so latency is
//   2 cycles, and the pipe accepts one request per cycle.
//
//   Optional feature: define GCID_STATS_EN to build the saturating 32-bit
//   statistics counters. Without it the o_cnt_* outputs are tied to 0.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   i_valid / o_ready     request handshake (o_ready is combinational)
//   i_cid                 {z,y,x} local codes, CID_W bits each
//   i_fold_id             fold index selecting the home cell
//   o_valid / i_ready     result handshake
//   o_gcid                {z,y,x} global cell IDs, GCID_W bits each
//   o_wrap_lo/o_wrap_hi   per-axis wrap flags {z,y,x}
//   o_err                 invalid axis code or out-of-range fold
//   o_cnt_conv/wrap/err   result statistics
module cid_to_gcid_3d_pipe #(
  parameter int CID_W     = 2,
  parameter int GCID_W    = 3,
  parameter int NUM_FOLDS = 1,
  parameter int FOLD_W    = 1,
  parameter int DIM_X     = 3,
  parameter int DIM_Y     = 3,
  parameter int DIM_Z     = 3,
  parameter logic [NUM_FOLDS-1:0][GCID_W-1:0] GCELL_X = '0,
  parameter logic [NUM_FOLDS-1:0][GCID_W-1:0] GCELL_Y = '0,
  parameter logic [NUM_FOLDS-1:0][GCID_W-1:0] GCELL_Z = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [3*CID_W-1:0]    i_cid,
  input  logic [FOLD_W-1:0]     i_fold_id,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [3*GCID_W-1:0]   o_gcid,
  output logic [2:0]            o_wrap_lo,
  output logic [2:0]            o_wrap_hi,
  output logic                  o_err,
  output logic [31:0]           o_cnt_conv,
  output logic [31:0]           o_cnt_wrap,
  output logic [31:0]           o_cnt_err
);

  localparam logic [GCID_W:0] DX_M1 = (GCID_W+1)'(DIM_X - 1);
  localparam logic [GCID_W:0] DY_M1 = (GCID_W+1)'(DIM_Y - 1);
  localparam logic [GCID_W:0] DZ_M1 = (GCID_W+1)'(DIM_Z - 1);

  // Returns {wrap_lo, wrap_hi, err, gcid}. The extra headroom bit keeps
  // home+1 from overflowing before the compare against DIM-1.
  function automatic logic [GCID_W+2:0] map_axis(
    input logic [CID_W-1:0]  code,
    input logic [GCID_W-1:0] home,
    input logic [GCID_W:0]   dim_m1
  );
    logic [GCID_W:0] h;
    logic [GCID_W:0] r;
    logic            lo;
    logic            hi;
    logic            e;
    h  = {1'b0, home};
    r  = '0;
    lo = 1'b0;
    hi = 1'b0;
    e  = 1'b0;
    case (code)
      CID_W'(1): begin
        if (h == '0) begin
          r  = dim_m1;
          lo = 1'b1;
        end else begin
          r  = h - (GCID_W+1)'(1);
        end
      end
      CID_W'(2): r = h;
      CID_W'(3): begin
        if (h == dim_m1) begin
          r  = '0;
          hi = 1'b1;
        end else begin
          r  = h + (GCID_W+1)'(1);
        end
      end
      default: e = 1'b1;
    endcase
    return {lo, hi, e, r[GCID_W-1:0]};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic adv;
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;

  // Home-cell lookup; an out-of-range fold leaves home at 0 and flags err.
  logic [GCID_W-1:0] home_x;
  logic [GCID_W-1:0] home_y;
  logic [GCID_W-1:0] home_z;
  logic              ferr;
  always_comb begin
    home_x = '0;
    home_y = '0;
    home_z = '0;
    ferr   = int'(i_fold_id) >= NUM_FOLDS;
    for (int f = 0; f < NUM_FOLDS; f++) begin
      if (int'(i_fold_id) == f) begin
        home_x = GCELL_X[f];
        home_y = GCELL_Y[f];
        home_z = GCELL_Z[f];
      end
    end
  end

  // ---- stage 1: code, home cell, fold error ----
  logic                 vld_p1;
  logic [3*CID_W-1:0]   cid_p1;
  logic [GCID_W-1:0]    home_x_p1;
  logic [GCID_W-1:0]    home_y_p1;
  logic [GCID_W-1:0]    home_z_p1;
  logic                 ferr_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= i_valid;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      cid_p1    <= i_cid;
      home_x_p1 <= home_x;
      home_y_p1 <= home_y;
      home_z_p1 <= home_z;
      ferr_p1   <= ferr;
    end
  end

  logic [GCID_W+2:0] mx;
  logic [GCID_W+2:0] my;
  logic [GCID_W+2:0] mz;
  assign mx = map_axis(cid_p1[CID_W-1:0],         home_x_p1, DX_M1);
  assign my = map_axis(cid_p1[2*CID_W-1:CID_W],   home_y_p1, DY_M1);
  assign mz = map_axis(cid_p1[3*CID_W-1:2*CID_W], home_z_p1, DZ_M1);

  // ---- stage 2: mapped result, drives outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_gcid    <= '0;
      o_wrap_lo <= '0;
      o_wrap_hi <= '0;
      o_err     <= 1'b0;
    end else if (adv) begin
      o_valid   <= vld_p1;
      o_gcid    <= {mz[GCID_W-1:0], my[GCID_W-1:0], mx[GCID_W-1:0]};
      o_wrap_lo <= {mz[GCID_W+2], my[GCID_W+2], mx[GCID_W+2]};
      o_wrap_hi <= {mz[GCID_W+1], my[GCID_W+1], mx[GCID_W+1]};
      o_err     <= ferr_p1 | mx[GCID_W] | my[GCID_W] | mz[GCID_W];
    end
  end

`ifdef GCID_STATS_EN
  logic fire;
  assign fire = o_valid && i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cnt_conv <= '0;
      o_cnt_wrap <= '0;
      o_cnt_err  <= '0;
    end else if (fire) begin
      o_cnt_conv <= sat_inc(o_cnt_conv);
      if ((|o_wrap_lo) || (|o_wrap_hi)) o_cnt_wrap <= sat_inc(o_cnt_wrap);
      if (o_err)                        o_cnt_err  <= sat_inc(o_cnt_err);
    end
  end
`else
  assign o_cnt_conv = '0;
  assign o_cnt_wrap = '0;
  assign o_cnt_err  = '0;
`endif

endmodule
